// File: rtl/interval_timer_sequencer_pkg.sv
// Shared definitions for the interval timer sequencer:
// timer register map, control bits and FSM encoding.
package interval_timer_sequencer_pkg;

   localparam logic [2:0] TMR_STATUS  = 3'd0;
   localparam logic [2:0] TMR_CONTROL = 3'd1;
   localparam logic [2:0] TMR_PERIODL = 3'd2;
   localparam logic [2:0] TMR_PERIODH = 3'd3;

   localparam int CTL_ITO   = 0;
   localparam int CTL_CONT  = 1;
   localparam int CTL_START = 2;
   localparam int CTL_STOP  = 3;

   localparam logic [15:0] CTL_RUN =
      (16'd1 << CTL_START) | (16'd1 << CTL_ITO);
   localparam logic [15:0] CTL_OFF = 16'h0000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_PL,
      S_WR_PH,
      S_WR_CTL,
      S_WAIT_IRQ,
      S_WR_STAT,
      S_WR_CTLOFF,
      S_DONE
   } state_t;

   // Timer counts period+1 ticks, so a delay of d needs period d-1.
   function automatic logic [31:0] period_of(input logic [31:0] d);
      return (d == 32'd0) ? 32'd0 : d - 32'd1;
   endfunction

endpackage

// File: rtl/interval_timer_sequencer_if.sv
// Avalon-MM write-only link between the sequencer and
// the interval timer s1 slave.
interface interval_timer_sequencer_if;
   logic [2:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic        tmr_irq;

   modport master (
      output tmr_address,
      output tmr_chipselect,
      output tmr_write_n,
      output tmr_writedata,
      input  tmr_irq
   );

   modport slave (
      input  tmr_address,
      input  tmr_chipselect,
      input  tmr_write_n,
      input  tmr_writedata,
      output tmr_irq
   );
endinterface

// File: rtl/interval_timer_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set
// request at or after i_ptr+1, wrapping modulo NUM_REQ.
module interval_timer_sequencer_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_valid
);

   logic [IDX_W-1:0] w_j;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_j     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_j = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
         if (!o_valid && i_req[w_j]) begin
            o_valid   = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_idx     = w_j;
         end
      end
   end

endmodule

// File: rtl/interval_timer_sequencer.sv
// Shares one interval timer among NUM_REQ requesters: arbitrates,
// programs a one-shot delay, waits for irq, clears it, signals done.
module interval_timer_sequencer
   import interval_timer_sequencer_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ*32-1:0]  delay,
   output logic [NUM_REQ-1:0]     done,
   output logic                   busy,
   output logic [IDX_W-1:0]       grant_idx,
   interval_timer_sequencer_if.master tmr
);

   state_t r_state, w_next;

   logic [IDX_W-1:0]   r_ptr, r_grant, w_idx;
   logic [NUM_REQ-1:0] w_gnt, r_gnt_oh, r_done, w_done;
   logic               w_vld;
   logic [31:0]        w_sel_delay, w_new_period;
   logic [15:0]        r_period_h;
   logic               r_busy, w_busy;
   logic               r_cs, w_cs, r_wn;
   logic [2:0]         r_addr, w_addr;
   logic [15:0]        r_wdata, w_wdata;

   interval_timer_sequencer_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_valid (w_vld)
   );

   always_comb begin
      w_sel_delay = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_idx == IDX_W'(i)) w_sel_delay = delay[32*i +: 32];
      end
      w_new_period = period_of(w_sel_delay);
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:      if (w_vld) w_next = S_WR_PL;
         S_WR_PL:     w_next = S_WR_PH;
         S_WR_PH:     w_next = S_WR_CTL;
         S_WR_CTL:    w_next = S_WAIT_IRQ;
         S_WAIT_IRQ:  if (tmr.tmr_irq) w_next = S_WR_STAT;
         S_WR_STAT:   w_next = S_WR_CTLOFF;
         S_WR_CTLOFF: w_next = S_DONE;
         S_DONE:      w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so each
   // write appears on the bus during the cycle its state is active.
   always_comb begin
      w_cs    = 1'b0;
      w_addr  = '0;
      w_wdata = '0;
      w_done  = '0;
      w_busy  = (w_next != S_IDLE);
      unique case (w_next)
         S_WR_PL: begin
            w_cs    = 1'b1;
            w_addr  = TMR_PERIODL;
            w_wdata = w_new_period[15:0];
         end
         S_WR_PH: begin
            w_cs    = 1'b1;
            w_addr  = TMR_PERIODH;
            w_wdata = r_period_h;
         end
         S_WR_CTL: begin
            w_cs    = 1'b1;
            w_addr  = TMR_CONTROL;
            w_wdata = CTL_RUN;
         end
         S_WR_STAT: begin
            w_cs    = 1'b1;
            w_addr  = TMR_STATUS;
         end
         S_WR_CTLOFF: begin
            w_cs    = 1'b1;
            w_addr  = TMR_CONTROL;
            w_wdata = CTL_OFF;
         end
         S_DONE:  w_done = r_gnt_oh;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_grant    <= '0;
         r_gnt_oh   <= '0;
         r_period_h <= '0;
         r_busy     <= 1'b0;
         r_done     <= '0;
         r_cs       <= 1'b0;
         r_wn       <= 1'b1;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_state <= w_next;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_cs    <= w_cs;
         r_wn    <= ~w_cs;
         r_addr  <= w_addr;
         r_wdata <= w_wdata;
         if (r_state == S_IDLE && w_vld) begin
            r_grant    <= w_idx;
            r_gnt_oh   <= w_gnt;
            r_period_h <= w_new_period[31:16];
         end
         if (r_state == S_DONE) r_ptr <= r_grant;
      end
   end

   assign done               = r_done;
   assign busy               = r_busy;
   assign grant_idx          = r_grant;
   assign tmr.tmr_address    = r_addr;
   assign tmr.tmr_chipselect = r_cs;
   assign tmr.tmr_write_n    = r_wn;
   assign tmr.tmr_writedata  = r_wdata;

endmodule

// File: tb/tb_interval_timer_sequencer.sv
// Directed bench for interval_timer_sequencer with a
// behavioural one-shot interval timer attached.
module tb_interval_timer_sequencer;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [3:0]   req = '0;
   logic [127:0] delay = '0;
   logic [3:0]   done;
   logic         busy;
   logic [1:0]   grant_idx;
   logic         stray = 1'b0;

   int nvec = 0;
   int nerr = 0;

   interval_timer_sequencer_if tif ();

   interval_timer_sequencer #(
      .NUM_REQ (4),
      .IDX_W   (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .delay     (delay),
      .done      (done),
      .busy      (busy),
      .grant_idx (grant_idx),
      .tmr       (tif)
   );

   always #5 clk = ~clk;

   // Timer: period+1 ticks after START, TO rises; irq = TO & ITO.
   logic        m_to, m_ito, m_run;
   logic [31:0] m_cnt, m_per;
   logic        m_wr;

   assign m_wr = tif.tmr_chipselect && !tif.tmr_write_n;
   assign tif.tmr_irq = (m_to & m_ito) | stray;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_to  <= 1'b0;
         m_ito <= 1'b0;
         m_run <= 1'b0;
         m_cnt <= '0;
         m_per <= '0;
      end else begin
         if (m_run) begin
            if (m_cnt == 0) begin
               m_to  <= 1'b1;
               m_run <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
         if (m_wr) begin
            case (tif.tmr_address)
               3'd0: m_to <= 1'b0;
               3'd1: begin
                  m_ito <= tif.tmr_writedata[0];
                  if (tif.tmr_writedata[2]) begin
                     m_cnt <= m_per;
                     m_run <= 1'b1;
                  end
                  if (tif.tmr_writedata[3]) m_run <= 1'b0;
               end
               3'd2: m_per[15:0]  <= tif.tmr_writedata;
               3'd3: m_per[31:16] <= tif.tmr_writedata;
               default: ;
            endcase
         end
      end
   end

   typedef struct packed {
      logic [2:0]  a;
      logic [15:0] d;
   } wr_t;

   int         cyc = 0;
   logic       busy_q = 1'b0;
   int         lowrun = 0;
   wr_t        wlog[$];
   int         glog[$];
   int         gcyc[$];
   int         gaps[$];
   logic [3:0] dlog[$];
   int         dcyc[$];

   always @(negedge clk) begin
      cyc++;
      if (m_wr) wlog.push_back({tif.tmr_address, tif.tmr_writedata});
      if (busy === 1'b1 && busy_q === 1'b0) begin
         glog.push_back(int'(grant_idx));
         gcyc.push_back(cyc);
         gaps.push_back(lowrun);
      end
      lowrun = (busy === 1'b1) ? 0 : lowrun + 1;
      if (done !== 4'b0000) begin
         dlog.push_back(done);
         dcyc.push_back(cyc);
      end
      busy_q = busy;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wlog.delete();
      glog.delete();
      gcyc.delete();
      gaps.delete();
      dlog.delete();
      dcyc.delete();
   endtask

   task automatic wait_done(input int budget, output bit to);
      to = 1'b1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (dlog.size() > 0) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      nvec++;
      if (busy !== 1'b0 || done !== 4'b0) begin
         nerr++;
         $display("FAIL rst_busy_done got %b/%b want 0/0000", busy, done);
      end
      nvec++;
      if (grant_idx !== 2'd0) begin
         nerr++;
         $display("FAIL rst_grant got %0d want 0", grant_idx);
      end
      nvec++;
      if (tif.tmr_chipselect !== 1'b0 || tif.tmr_write_n !== 1'b1) begin
         nerr++;
         $display("FAIL rst_bus cs/wn got %b/%b want 0/1",
                  tif.tmr_chipselect, tif.tmr_write_n);
      end
      nvec++;
      if (tif.tmr_address !== 3'd0 || tif.tmr_writedata !== 16'h0) begin
         nerr++;
         $display("FAIL rst_addr_data got %0d/%h want 0/0000",
                  tif.tmr_address, tif.tmr_writedata);
      end
      reset = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_single();
      bit  to;
      wr_t exp[5];
      int  lat;
      exp[0] = {3'd2, 16'h0063};
      exp[1] = {3'd3, 16'h0000};
      exp[2] = {3'd1, 16'h0005};
      exp[3] = {3'd0, 16'h0000};
      exp[4] = {3'd1, 16'h0000};
      clear_logs();
      delay[31:0] = 32'd100;
      req[0] = 1'b1;
      wait_done(400, to);
      req[0] = 1'b0;
      repeat (6) tick();
      nvec++;
      if (to) begin
         nerr++;
         $display("FAIL single_timeout got no done want done[0]");
      end
      nvec++;
      if (wlog.size() !== 5) begin
         nerr++;
         $display("FAIL single_nwr got %0d want 5", wlog.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            nvec++;
            if (wlog[k] !== exp[k]) begin
               nerr++;
               $display("FAIL single_wr%0d got %0d,%h want %0d,%h",
                        k, wlog[k].a, wlog[k].d, exp[k].a, exp[k].d);
            end
         end
      end
      nvec++;
      if (dlog.size() !== 1 || dlog[0] !== 4'b0001) begin
         nerr++;
         $display("FAIL single_done got n=%0d v=%b want n=1 v=0001",
                  dlog.size(), dlog.size() ? dlog[0] : 4'bx);
      end
      if (dlog.size() > 0 && gcyc.size() > 0) begin
         lat = dcyc[0] - gcyc[0];
         nvec++;
         if (lat < 106 || lat > 107) begin
            nerr++;
            $display("FAIL single_lat got %0d want 106..107", lat);
         end
      end
      nvec++;
      if (glog.size() !== 1 || glog[0] !== 0) begin
         nerr++;
         $display("FAIL single_grant got n=%0d want one grant of 0",
                  glog.size());
      end
   endtask

   task automatic test_round_robin();
      int         eg[5];
      logic [3:0] ed[5];
      int         lat;
      bit         to;
      eg = '{1, 2, 3, 0, 1};
      ed = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      clear_logs();
      for (int i = 0; i < 4; i++) delay[32*i +: 32] = 32'd5;
      req = 4'b1111;
      to = 1'b1;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (dlog.size() >= 5) begin
            to = 1'b0;
            break;
         end
      end
      req = 4'b0000;
      repeat (5) tick();
      nvec++;
      if (to || glog.size() !== 5 || dlog.size() !== 5) begin
         nerr++;
         $display("FAIL rr_count got g=%0d d=%0d want 5/5",
                  glog.size(), dlog.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            nvec++;
            if (glog[k] !== eg[k] || dlog[k] !== ed[k]) begin
               nerr++;
               $display("FAIL rr_%0d got g=%0d d=%b want g=%0d d=%b",
                        k, glog[k], dlog[k], eg[k], ed[k]);
            end
            lat = dcyc[k] - gcyc[k];
            nvec++;
            if (lat < 11 || lat > 12) begin
               nerr++;
               $display("FAIL rr_lat%0d got %0d want 11..12", k, lat);
            end
         end
         for (int k = 1; k < 5; k++) begin
            nvec++;
            if (gaps[k] !== 1) begin
               nerr++;
               $display("FAIL rr_gap%0d got %0d want 1", k, gaps[k]);
            end
         end
      end
   endtask

   task automatic test_delay_zero();
      bit to;
      int lat;
      for (int r = 0; r < 2; r++) begin
         clear_logs();
         delay[127:96] = (r == 0) ? 32'd1 : 32'd0;
         req[3] = 1'b1;
         wait_done(100, to);
         req[3] = 1'b0;
         repeat (4) tick();
         nvec++;
         if (to || wlog.size() < 3) begin
            nerr++;
            $display("FAIL zero%0d_run got nwr=%0d want done", r,
                     wlog.size());
         end else begin
            nvec++;
            if (wlog[0] !== {3'd2, 16'h0} || wlog[1] !== {3'd3, 16'h0}) begin
               nerr++;
               $display("FAIL zero%0d_period got %h/%h want 0/0",
                        r, wlog[0].d, wlog[1].d);
            end
            lat = dcyc[0] - gcyc[0];
            nvec++;
            if (lat < 7 || lat > 8 || dlog[0] !== 4'b1000) begin
               nerr++;
               $display("FAIL zero%0d_lat got %0d,%b want 7..8,1000",
                        r, lat, dlog[0]);
            end
         end
      end
   endtask

   task automatic test_req_drop();
      bit to;
      int lat;
      clear_logs();
      delay[63:32] = 32'd10;
      req[1] = 1'b1;
      for (int k = 0; k < 10 && busy !== 1'b1; k++) tick();
      tick();
      req[1] = 1'b0;
      wait_done(100, to);
      repeat (4) tick();
      nvec++;
      if (to || dlog.size() !== 1 || dlog[0] !== 4'b0010) begin
         nerr++;
         $display("FAIL drop_done got n=%0d want one pulse 0010",
                  dlog.size());
      end else begin
         lat = dcyc[0] - gcyc[0];
         nvec++;
         if (lat < 16 || lat > 17) begin
            nerr++;
            $display("FAIL drop_lat got %0d want 16..17", lat);
         end
      end
      clear_logs();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      repeat (8) tick();
      nvec++;
      if (wlog.size() !== 0 || dlog.size() !== 0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL stray_irq got wr=%0d done=%0d busy=%b want 0/0/0",
                  wlog.size(), dlog.size(), busy);
      end
   endtask

   task automatic test_large();
      bit to;
      int lat;
      clear_logs();
      delay[95:64] = 32'h0001_0000;
      req[2] = 1'b1;
      wait_done(70000, to);
      req[2] = 1'b0;
      repeat (4) tick();
      nvec++;
      if (to || wlog.size() < 3) begin
         nerr++;
         $display("FAIL large_run got nwr=%0d want done", wlog.size());
      end else begin
         nvec++;
         if (wlog[0] !== {3'd2, 16'hFFFF} || wlog[1] !== {3'd3, 16'h0}
             || wlog[2] !== {3'd1, 16'h0005}) begin
            nerr++;
            $display("FAIL large_wr got %h %h %h want FFFF 0000 0005",
                     wlog[0].d, wlog[1].d, wlog[2].d);
         end
         lat = dcyc[0] - gcyc[0];
         nvec++;
         if (lat < 65542 || lat > 65543 || dlog[0] !== 4'b0100) begin
            nerr++;
            $display("FAIL large_lat got %0d,%b want 65542..65543,0100",
                     lat, dlog[0]);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int lat;
      clear_logs();
      delay[31:0] = 32'd50;
      req[0] = 1'b1;
      for (int k = 0; k < 20 && wlog.size() < 3; k++) tick();
      repeat (5) tick();
      nvec++;
      if (busy !== 1'b1 || wlog.size() !== 3) begin
         nerr++;
         $display("FAIL mid_pre got busy=%b nwr=%0d want 1/3",
                  busy, wlog.size());
      end
      reset = 1'b1;
      #1;
      nvec++;
      if (busy !== 1'b0 || tif.tmr_chipselect !== 1'b0
          || tif.tmr_write_n !== 1'b1) begin
         nerr++;
         $display("FAIL mid_async got busy/cs/wn %b%b%b want 001",
                  busy, tif.tmr_chipselect, tif.tmr_write_n);
      end
      tick();
      clear_logs();
      reset = 1'b0;
      wait_done(200, to);
      req[0] = 1'b0;
      repeat (4) tick();
      nvec++;
      if (to || wlog.size() !== 5 || glog.size() !== 1) begin
         nerr++;
         $display("FAIL mid_rerun got nwr=%0d ng=%0d want 5/1",
                  wlog.size(), glog.size());
      end else begin
         nvec++;
         if (wlog[0] !== {3'd2, 16'd49} || glog[0] !== 0) begin
            nerr++;
            $display("FAIL mid_first got %0d,%h g=%0d want 2,0031 g=0",
                     wlog[0].a, wlog[0].d, glog[0]);
         end
         lat = dcyc[0] - gcyc[0];
         nvec++;
         if (lat < 56 || lat > 57 || dlog[0] !== 4'b0001) begin
            nerr++;
            $display("FAIL mid_lat got %0d,%b want 56..57,0001",
                     lat, dlog[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_delay_zero();
      test_req_drop();
      test_large();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
